adc_mag_lookup_filter: RTL

- Parametrised successor of the single-channel ADC → EPROM → consumer pipeline.
- Per sample:
  - Starts a conversion with the ADC using the SOC/EOC handshake, then latches the signed sample.
  - Reads an external ROM at the sample's magnitude, with a configurable number of wait states.
  - Filters the ROM word against a constant accept mask.
  - Hands accepted results to a consumer over the DAV_/RFD handshake.
- New over the previous generation: generic widths, ROM latency, output-select mode, latched sample, and a saturating reject counter.

---
 rtl/adc_mag_lookup_filter_pkg.sv | 22 ++
 rtl/adc_mag_lookup_filter_if.sv | 30 +++
 rtl/adc_mag_lookup_filter_signed_mag.sv | 12 +
 rtl/adc_mag_lookup_filter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/adc_mag_lookup_filter_pkg.sv
// Shared types and constants for the ADC magnitude lookup filter.
// Holds the FSM state encoding, the output-select codes and the default accept mask.
package adc_filter_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CONV,
    RD,
    OUT,
    ACK
  } state_t;

  localparam int OUT_RAW = 0;
  localparam int OUT_MAG = 1;
  localparam int OUT_ROM = 2;

  localparam int LAT_MAX = 15;

  // Accepts ROM words 2, 3, 5, 7, 11 and 13.
  localparam logic [15:0] DEF_ACCEPT_MASK = 16'h28AC;

endpackage

// File: rtl/adc_mag_lookup_filter_if.sv
// ADC / ROM / consumer signal bundle; master is the filter, slave is the environment.
// Active-low strobes keep their trailing underscore (mr_, dav_).
interface adc_mag_lookup_filter_if #(
  parameter int W  = 8,
  parameter int DW = 4,
  parameter int CW = 8
);
  logic          soc;
  logic          eoc;
  logic [W-1:0]  x;
  logic          mr_;
  logic [W-1:0]  addr;
  logic [DW-1:0] mdata;
  logic          dav_;
  logic          rfd;
  logic [W-1:0]  y;
  logic [CW-1:0] rej_cnt;
  logic          busy;

  modport master (
    output soc, mr_, addr, dav_, y, rej_cnt, busy,
    input  eoc, x, mdata, rfd
  );

  modport slave (
    input  soc, mr_, addr, dav_, y, rej_cnt, busy,
    output eoc, x, mdata, rfd
  );

endinterface

// File: rtl/adc_mag_lookup_filter_signed_mag.sv
// Combinational two's-complement magnitude; the most negative value maps to itself,
// which read as unsigned is exactly its magnitude.
module signed_mag #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  output logic [W-1:0] mag
);

  assign mag = x[W-1] ? ((~x) + {{(W-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/adc_mag_lookup_filter.sv
// ADC sample -> ROM lookup at |x| -> accept-mask filter -> DAV_/RFD hand-off to consumer.
// ROM word sampled MEM_LAT+1 edges after mr_ falls; the FSM stalls in OUT/ACK until the consumer handshakes.
module adc_mag_lookup_filter
  import adc_filter_pkg::*;
#(
  parameter int               W           = 8,
  parameter int               DW          = 4,
  parameter int               MEM_LAT     = 1,
  parameter logic [2**DW-1:0] ACCEPT_MASK = DEF_ACCEPT_MASK,
  parameter int               OUT_SEL     = OUT_RAW,
  parameter int               CW          = 8
) (
  input logic                   clock,
  input logic                   reset,
  adc_mag_lookup_filter_if.master bus
);

  if (DW > W) begin : g_bad_dw
    $error("adc_mag_lookup_filter: DW must not exceed W");
  end
  if (OUT_SEL < OUT_RAW || OUT_SEL > OUT_ROM) begin : g_bad_sel
    $error("adc_mag_lookup_filter: OUT_SEL must be 0, 1 or 2");
  end
  if (MEM_LAT < 0 || MEM_LAT > LAT_MAX) begin : g_bad_lat
    $error("adc_mag_lookup_filter: MEM_LAT must be in 0..15");
  end

  state_t        state;
  logic [3:0]    cnt;
  logic [W-1:0]  x_q;
  logic [W-1:0]  mag_x;
  logic [W-1:0]  mag_q;
  logic [W-1:0]  sel_val;
  logic          soc;
  logic          mr_;
  logic          dav_;
  logic [W-1:0]  addr;
  logic [W-1:0]  y;
  logic [CW-1:0] rej_cnt;

  // Live magnitude drives the ROM address; the latched one feeds y.
  signed_mag #(.W(W)) u_mag_addr (.x(bus.x), .mag(mag_x));
  signed_mag #(.W(W)) u_mag_y    (.x(x_q),   .mag(mag_q));

  always_comb begin
    sel_val = x_q;
    case (OUT_SEL)
      OUT_MAG: sel_val = mag_q;
      OUT_ROM: sel_val = W'(bus.mdata);
      default: sel_val = x_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      x_q     <= '0;
      soc     <= 1'b0;
      mr_     <= 1'b1;
      dav_    <= 1'b1;
      addr    <= '0;
      y       <= '0;
      rej_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          soc <= 1'b1;
          if (soc && !bus.eoc) begin
            soc   <= 1'b0;
            state <= CONV;
          end
        end
        CONV: begin
          if (bus.eoc) begin
            x_q   <= bus.x;
            addr  <= mag_x;
            mr_   <= 1'b0;
            cnt   <= 4'(MEM_LAT);
            state <= RD;
          end
        end
        RD: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            mr_ <= 1'b1;
            if (ACCEPT_MASK[bus.mdata]) begin
              y     <= sel_val;
              dav_  <= 1'b0;
              state <= OUT;
            end else begin
              if (rej_cnt != {CW{1'b1}}) rej_cnt <= rej_cnt + CW'(1);
              state <= IDLE;
            end
          end
        end
        OUT: begin
          if (!bus.rfd) begin
            dav_  <= 1'b1;
            state <= ACK;
          end
        end
        ACK: begin
          if (bus.rfd) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.soc     = soc;
  assign bus.mr_     = mr_;
  assign bus.dav_    = dav_;
  assign bus.addr    = addr;
  assign bus.y       = y;
  assign bus.rej_cnt = rej_cnt;
  assign bus.busy    = (state != IDLE);

endmodule
